// File: rtl/layer4_node_sequencer.sv
// Sequencer around one combinational layer-4 neuron node: deserialises activations into a
// parallel bank, waits a fixed settle time, then offers the ReLU-guarded result downstream.
module layer4_node_sequencer #(
  parameter int N_IN          = 15,
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic [N_IN*DATA_W-1:0]   act_bus,
  input  logic [DATA_W-1:0]        node_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     frame_err
);

  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CW-1:0] LAST_SLOT   = CW'(N_IN - 1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {FILL, SETTLE, HOLD} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic [3:0]      settle_cnt;
  logic            last_slot;
  logic            accept;
  logic            capture;

  assign last_slot = (count == LAST_SLOT);
  assign accept    = in_valid && in_ready;
  assign capture   = (state == SETTLE) && (settle_cnt == SETTLE_LAST);

  // While a result is unaccepted the final word may only enter alongside the handshake,
  // so a completed vector can never overwrite a result still waiting downstream.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      FILL:    in_ready = 1'b1;
      HOLD:    in_ready = !last_slot || out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (accept && last_slot)
          state_next = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST)
          state_next = HOLD;
      end
      HOLD: begin
        if (out_ready)
          state_next = (accept && last_slot) ? SETTLE : FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      count      <= '0;
      settle_cnt <= '0;
      act_bus    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= (state == SETTLE) ? settle_cnt + 4'd1 : 4'd0;

      if (accept) begin
        act_bus[count*DATA_W +: DATA_W] <= in_data;
        count <= last_slot ? '0 : count + CW'(1);
        // in_last is advisory only; disagreement with the count is flagged, never acted on
        if (in_last != last_slot)
          frame_err <= 1'b1;
      end

      if (capture) begin
        out_data  <= node_result[DATA_W-1] ? '0 : node_result;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_layer4_node_sequencer.sv
// Self-checking bench for layer4_node_sequencer: scoreboard of expected results and capture
// timing, filled when the final word of a vector is accepted and drained as results appear.
module tb_layer4_node_sequencer;

  localparam int N_IN   = 15;
  localparam int DATA_W = 32;
  localparam int SETTLE = 4;

  typedef struct {
    logic [31:0] data;
    int          rise;
  } exp_t;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    in_last;
  logic [N_IN*DATA_W-1:0]  act_bus;
  logic [DATA_W-1:0]       node_result;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    frame_err;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t exp_q[$];

  layer4_node_sequencer #(
    .N_IN(N_IN), .DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .act_bus(act_bus), .node_result(node_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] relu(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Presents one word at a negedge and holds it until the DUT takes it; returns the cycle of acceptance.
  task automatic send_word(input logic [31:0] d, input logic last, output logic ok, output int acc);
    logic rdy;
    ok = 1'b0; acc = -1;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int i = 0; i < 200; i++) begin
      #1;
      rdy = in_ready;
      acc = cyc;
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] val, input logic use_idx, input int last_pos,
                               input logic gaps, input int first, input int last_word);
    logic ok;
    int   acc;
    exp_t e;
    for (int i = first; i <= last_word; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
      send_word(use_idx ? val + 32'(i) : val, (i == last_pos), ok, acc);
      if (!ok) begin
        compared++; mismatched++;
        $display("[TB] FAIL word_accept_timeout: word %0d got no in_ready, required acceptance", i);
      end else if (i == N_IN-1) begin
        e.data = relu(node_result);
        e.rise = acc + SETTLE + 1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic await_pop(output logic seen, output int rise, output logic [31:0] data, output exp_t e);
    seen = 1'b0; rise = -1; data = 'x;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        seen = 1'b1; rise = cyc; data = out_data;
        break;
      end
      @(negedge clk);
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.data = 'x; e.rise = -2;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    node_result = '0;
    #1;
    compared++; if (act_bus !== '0) begin mismatched++; $display("[TB] FAIL reset_act_bus: got %h required 0", act_bus); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    compared++; if (out_data !== '0) begin mismatched++; $display("[TB] FAIL reset_out_data: got %h required 0", out_data); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame_err: got %b required 0", frame_err); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic seen; int rise; logic [31:0] data; exp_t e;
    node_result = 32'h4000_0000;
    applyStimulus(32'h3F80_0000, 1'b0, N_IN-1, 1'b0, 0, N_IN-1);
    compared++; if (act_bus !== {N_IN{32'h3F80_0000}}) begin mismatched++; $display("[TB] FAIL basic_act_bus: got %h required all 3f800000", act_bus); end
    await_pop(seen, rise, data, e);
    compared++; if (seen !== 1'b1 || rise !== e.rise) begin mismatched++; $display("[TB] FAIL basic_latency: got cycle %0d (seen %b) required %0d", rise, seen, e.rise); end
    compared++; if (data !== e.data) begin mismatched++; $display("[TB] FAIL basic_out_data: got %h required %h", data, e.data); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_frame_err: got %b required 0", frame_err); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_valid_drop: got %b required 0", out_valid); end
  endtask

  task automatic test_relu();
    logic seen; int rise; logic [31:0] data; exp_t e;
    node_result = 32'hBF80_0000;
    applyStimulus(32'h3F80_0000, 1'b0, N_IN-1, 1'b0, 0, N_IN-1);
    await_pop(seen, rise, data, e);
    compared++; if (seen !== 1'b1 || rise !== e.rise) begin mismatched++; $display("[TB] FAIL relu_latency: got cycle %0d (seen %b) required %0d", rise, seen, e.rise); end
    compared++; if (data !== e.data) begin mismatched++; $display("[TB] FAIL relu_out_data: got %h required %h", data, e.data); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic seen; int rise; logic [31:0] data; exp_t e; logic ok; int acc; exp_t e2;
    int stall_bad;
    out_ready = 1'b0;
    node_result = 32'h4120_0000;
    applyStimulus(32'h3F00_0000, 1'b0, N_IN-1, 1'b0, 0, N_IN-1);
    await_pop(seen, rise, data, e);
    compared++; if (seen !== 1'b1 || rise !== e.rise) begin mismatched++; $display("[TB] FAIL b2b_first_latency: got cycle %0d (seen %b) required %0d", rise, seen, e.rise); end
    compared++; if (data !== e.data) begin mismatched++; $display("[TB] FAIL b2b_first_data: got %h required %h", data, e.data); end
    node_result = 32'h4130_0000;
    applyStimulus(32'h4000_0000, 1'b1, N_IN-1, 1'b0, 0, N_IN-2);
    in_valid = 1'b1; in_data = 32'h4000_000E; in_last = 1'b1;
    stall_bad = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== e.data) stall_bad++;
      @(negedge clk);
    end
    compared++; if (stall_bad != 0) begin mismatched++; $display("[TB] FAIL b2b_stall: got %0d bad stall cycles required 0 (out_data %h hold %h)", stall_bad, out_data, e.data); end
    out_ready = 1'b1;
    send_word(32'h4000_000E, 1'b1, ok, acc);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_final_accept: got %b required 1", ok); end
    e2.data = relu(node_result); e2.rise = acc + SETTLE + 1;
    if (ok) exp_q.push_back(e2);
    await_pop(seen, rise, data, e);
    compared++; if (seen !== 1'b1 || rise !== e.rise) begin mismatched++; $display("[TB] FAIL b2b_second_latency: got cycle %0d (seen %b) required %0d", rise, seen, e.rise); end
    compared++; if (data !== e.data) begin mismatched++; $display("[TB] FAIL b2b_second_data: got %h required %h", data, e.data); end
    @(negedge clk);
  endtask

  task automatic test_frame_err();
    logic seen; int rise; logic [31:0] data; exp_t e;
    do_reset();
    node_result = 32'h3F00_0000;
    applyStimulus(32'h0, 1'b1, 7, 1'b0, 0, 6);
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL frame_before: got %b required 0", frame_err); end
    applyStimulus(32'h0, 1'b1, 7, 1'b0, 7, 7);
    compared++; if (frame_err !== 1'b1) begin mismatched++; $display("[TB] FAIL frame_set: got %b required 1", frame_err); end
    applyStimulus(32'h0, 1'b1, 7, 1'b0, 8, N_IN-1);
    await_pop(seen, rise, data, e);
    compared++; if (seen !== 1'b1 || data !== e.data) begin mismatched++; $display("[TB] FAIL frame_result: got %h (seen %b) required %h", data, seen, e.data); end
    @(negedge clk);
    compared++; if (frame_err !== 1'b1) begin mismatched++; $display("[TB] FAIL frame_sticky: got %b required 1", frame_err); end
    do_reset();
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL frame_clear: got %b required 0", frame_err); end
  endtask

  task automatic test_gaps();
    logic seen; int rise; logic [31:0] data; exp_t e;
    node_result = 32'h1234_5678;
    applyStimulus(32'h0, 1'b1, N_IN-1, 1'b1, 0, N_IN-1);
    for (int k = 0; k < N_IN; k++) begin
      compared++;
      if (act_bus[k*DATA_W +: DATA_W] !== 32'(k)) begin
        mismatched++;
        $display("[TB] FAIL gaps_slot%0d: got %h required %h", k, act_bus[k*DATA_W +: DATA_W], 32'(k));
      end
    end
    await_pop(seen, rise, data, e);
    compared++; if (seen !== 1'b1 || rise !== e.rise || data !== e.data) begin mismatched++; $display("[TB] FAIL gaps_result: got %h @%0d required %h @%0d", data, rise, e.data, e.rise); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic seen; int rise; logic [31:0] data; exp_t e;
    node_result = 32'h4040_0000;
    applyStimulus(32'hA5A5_0000, 1'b1, N_IN-1, 1'b0, 0, 9);
    rst_n = 1'b0;
    #1;
    compared++; if (act_bus !== '0) begin mismatched++; $display("[TB] FAIL midrst_act_bus: got %h required 0", act_bus); end
    compared++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_handshake: got in_ready %b out_valid %b required 1 0", in_ready, out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'h3F80_0000, 1'b0, N_IN-1, 1'b0, 0, N_IN-1);
    compared++; if (act_bus !== {N_IN{32'h3F80_0000}}) begin mismatched++; $display("[TB] FAIL midrst_refill: got %h required all 3f800000", act_bus); end
    await_pop(seen, rise, data, e);
    compared++; if (seen !== 1'b1 || rise !== e.rise || data !== e.data) begin mismatched++; $display("[TB] FAIL midrst_result: got %h @%0d required %h @%0d", data, rise, e.data, e.rise); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b1; node_result = '0;
    test_reset();
    test_basic();
    test_relu();
    test_back_to_back();
    test_frame_err();
    test_gaps();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
